ra_host_sdr_32x32: RTL and testbench

Host-side command front end for the 2R1W 32x32 SDR test array. It accepts single read, dual read and write requests over a valid/ready port and drives the array's functional inputs (`rd_enb_0/1`, `rd_adr_0/1`, `wr_enb_0`, `wr_adr_0`, `wr_dat_0`). It captures `rd_dat_0/1` after the array's read latency and returns them through a buffered, back-pressurable response port. It sits directly upstream of the test array top, in place of raw pin or register drive.

---
 rtl/ra_host_pkg.sv | 16 +
 rtl/ra_host_rsp_fifo.sv | 39 +++
 rtl/ra_host_sdr_32x32.sv | 97 +++++++++
 tb/tb_ra_host_sdr_32x32.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ra_host_pkg.sv
// ra_host_pkg: op encodings and in-flight stage record shared by the host front end.
package ra_host_pkg;
    localparam logic [1:0] OP_RD0 = 2'b00;
    localparam logic [1:0] OP_RD1 = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;
    localparam logic [1:0] OP_RD2 = 2'b11;
    localparam int TAG_W = 4;
    localparam int ADR_W = 5;
    localparam int DAT_W = 32;
    localparam int RSP_W = TAG_W + 2 * DAT_W;
    typedef struct packed {
        logic             vld;
        logic [1:0]       mask;
        logic [TAG_W-1:0] tag;
    } stage_t;
endpackage

// File: rtl/ra_host_rsp_fifo.sv
// ra_host_rsp_fifo: synchronous response FIFO with occupancy count.
module ra_host_rsp_fifo
    import ra_host_pkg::*;
#(
    parameter int W     = RSP_W,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_pop;

    assign do_pop = pop && count != '0;
    assign dout = mem[rd_ptr];

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/ra_host_sdr_32x32.sv
// ra_host_sdr_32x32: valid/ready command front end for the 2R1W 32x32 SDR array,
// with credit-based flow control into a buffered response port.
module ra_host_sdr_32x32
    import ra_host_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [ADR_W-1:0] req_adr0,
    input  logic [ADR_W-1:0] req_adr1,
    input  logic [DAT_W-1:0] req_dat,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [DAT_W-1:0] rsp_dat0,
    output logic [DAT_W-1:0] rsp_dat1,
    output logic             rd_enb_0,
    output logic             rd_enb_1,
    output logic [ADR_W-1:0] rd_adr_0,
    output logic [ADR_W-1:0] rd_adr_1,
    input  logic [DAT_W-1:0] rd_dat_0,
    input  logic [DAT_W-1:0] rd_dat_1,
    output logic             wr_enb_0,
    output logic [ADR_W-1:0] wr_adr_0,
    output logic [DAT_W-1:0] wr_dat_0,
    output logic             busy
);
    localparam int CW = $clog2(DEPTH) + 1;
    stage_t pipe [RD_LAT+1];
    stage_t cap;
    logic [CW-1:0] fifo_count, inflight;
    logic [RSP_W-1:0] fifo_dout;
    logic acc, rd0, rd1;

    assign rd0 = req_op == OP_RD0 || req_op == OP_RD2;
    assign rd1 = req_op == OP_RD1 || req_op == OP_RD2;
    // Every in-flight read owns a FIFO slot, so a capture can never overflow.
    assign req_ready = !reset && ({1'b0, fifo_count} + {1'b0, inflight} < (CW+1)'(DEPTH));
    assign acc = req_valid && req_ready;
    assign cap = pipe[RD_LAT];
    assign rsp_valid = !reset && fifo_count != '0;
    assign {rsp_tag, rsp_dat0, rsp_dat1} = rsp_valid ? fifo_dout : '0;
    assign busy = !reset && (inflight != '0 || fifo_count != '0);

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= RD_LAT; i++) inflight = inflight + CW'(pipe[i].vld);
    end

    // Stage 0 lines up with the array enables; stage RD_LAT with valid read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= RD_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{vld: acc && req_op != OP_WR, mask: {rd1, rd0}, tag: req_tag};
            for (int i = 1; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_enb_0 <= 1'b0;
            rd_enb_1 <= 1'b0;
            wr_enb_0 <= 1'b0;
            rd_adr_0 <= '0;
            rd_adr_1 <= '0;
            wr_adr_0 <= '0;
            wr_dat_0 <= '0;
        end else begin
            rd_enb_0 <= acc && rd0;
            rd_enb_1 <= acc && rd1;
            wr_enb_0 <= acc && req_op == OP_WR;
            if (acc) begin
                rd_adr_0 <= req_adr0;
                rd_adr_1 <= req_adr1;
                wr_adr_0 <= req_adr0;
                wr_dat_0 <= req_dat;
            end
        end
    end

    ra_host_rsp_fifo #(.W(RSP_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cap.vld),
        .din   ({cap.tag, {DAT_W{cap.mask[0]}} & rd_dat_0, {DAT_W{cap.mask[1]}} & rd_dat_1}),
        .pop   (rsp_valid && rsp_ready),
        .dout  (fifo_dout),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_ra_host_sdr_32x32.sv
// tb_ra_host_sdr_32x32: scoreboard bench with a functional memory model and a cycle model of the array.
module tb_ra_host_sdr_32x32;
    logic clk = 0, reset = 1;
    logic req_valid = 0, req_ready;
    logic [1:0] req_op = 0;
    logic [3:0] req_tag = 0;
    logic [4:0] req_adr0 = 0, req_adr1 = 0;
    logic [31:0] req_dat = 0;
    logic rsp_valid, rsp_ready;
    logic [3:0] rsp_tag;
    logic [31:0] rsp_dat0, rsp_dat1;
    logic rd_enb_0, rd_enb_1, wr_enb_0, busy;
    logic [4:0] rd_adr_0, rd_adr_1, wr_adr_0;
    logic [31:0] rd_dat_0 = 0, rd_dat_1 = 0, wr_dat_0;
    logic rand_mode = 0, rdy_dir = 1, rdy_rand = 1;
    assign rsp_ready = rand_mode ? rdy_rand : rdy_dir;

    ra_host_sdr_32x32 #(.RD_LAT(1), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_tag(req_tag), .req_adr0(req_adr0), .req_adr1(req_adr1),
        .req_dat(req_dat), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
        .rsp_dat0(rsp_dat0), .rsp_dat1(rsp_dat1), .rd_enb_0(rd_enb_0), .rd_enb_1(rd_enb_1),
        .rd_adr_0(rd_adr_0), .rd_adr_1(rd_adr_1), .rd_dat_0(rd_dat_0), .rd_dat_1(rd_dat_1),
        .wr_enb_0(wr_enb_0), .wr_adr_0(wr_adr_0), .wr_dat_0(wr_dat_0), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0, stall_n = 0;
    logic [67:0] exp_q[$];
    int rsp_cycles[$];
    logic [31:0] ref_mem [32] = '{default: 32'h0};
    logic [31:0] amem [32] = '{default: 32'h0};
    logic held = 0;
    logic [67:0] held_val = 0;

    task automatic chk(input string nm, input logic [67:0] got, input logic [67:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // The array itself: one-cycle registered read, write lands at the clock edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_enb_0) amem[wr_adr_0] <= wr_dat_0;
        if (rd_enb_0) rd_dat_0 <= amem[rd_adr_0];
        if (rd_enb_1) rd_dat_1 <= amem[rd_adr_1];
    end

    initial forever begin
        @(posedge clk); #1;
        rdy_rand = $urandom_range(0, 3) != 0;
    end

    // Functional reference: every accepted read returns the memory contents as of its turn.
    always @(negedge clk) begin
        if (reset) exp_q.delete();
        else begin
            if (req_valid && !req_ready) stall_n++;
            if (req_valid && req_ready) begin
                if (req_op == 2'b10) ref_mem[req_adr0] = req_dat;
                else exp_q.push_back({req_tag,
                    (req_op == 2'b00 || req_op == 2'b11) ? ref_mem[req_adr0] : 32'h0,
                    (req_op == 2'b01 || req_op == 2'b11) ? ref_mem[req_adr1] : 32'h0});
            end
        end
    end

    always @(negedge clk) begin
        if (reset) held = 0;
        else begin
            if (held) begin
                chk("rsp_hold_valid", rsp_valid, 1);
                chk("rsp_hold_data", {rsp_tag, rsp_dat0, rsp_dat1}, held_val);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
                else chk("rsp_payload", {rsp_tag, rsp_dat0, rsp_dat1}, exp_q.pop_front());
                rsp_cycles.push_back(cyc);
            end
            held = rsp_valid && !rsp_ready;
            held_val = {rsp_tag, rsp_dat0, rsp_dat1};
        end
    end

    task automatic send(input logic [1:0] op, input logic [3:0] tag, input logic [4:0] a0,
                        input logic [4:0] a1, input logic [31:0] d);
        int n = 0;
        req_op = op; req_tag = tag; req_adr0 = a0; req_adr1 = a1; req_dat = d;
        req_valid = 1;
        @(negedge clk);
        while (!req_ready && n < 100) begin n++; @(negedge clk); end
        if (n == 100) chk("req_ready_timeout", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && n < 200) begin n++; @(negedge clk); end
        chk("drain_timeout", exp_q.size(), 0);
        chk("drain_busy", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int nacc, s0, r0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {req_ready, rsp_valid, busy, rd_enb_0, rd_enb_1, wr_enb_0, rsp_tag, rsp_dat0, rsp_dat1}, 0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1);
        @(posedge clk); #1;

        send(2'b10, 4'd0, 5'd5, 5'd0, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_pulse", {wr_enb_0, wr_adr_0, wr_dat_0, rd_enb_0, rd_enb_1}, {1'b1, 5'd5, 32'hDEADBEEF, 2'b00});
        @(posedge clk); #1;
        send(2'b00, 4'd3, 5'd5, 5'd0, 32'h0);
        @(negedge clk);
        chk("wr_enb_single", wr_enb_0, 0);
        chk("rd0_issue", {rd_enb_0, rd_enb_1, rd_adr_0}, {2'b10, 5'd5});
        @(negedge clk);
        chk("rsp_not_early", rsp_valid, 0);
        @(negedge clk);
        chk("rsp_at_accept_plus3", {rsp_valid, rsp_tag, rsp_dat0, rsp_dat1}, {1'b1, 4'd3, 32'hDEADBEEF, 32'h0});
        drain();

        send(2'b10, 4'd0, 5'd1, 5'd0, 32'h11111111);
        send(2'b10, 4'd0, 5'd31, 5'd0, 32'h31313131);
        send(2'b11, 4'd6, 5'd1, 5'd31, 32'h0);
        @(negedge clk);
        chk("dual_enables", {rd_enb_0, rd_enb_1, rd_adr_0, rd_adr_1}, {2'b11, 5'd1, 5'd31});
        drain();

        rdy_dir = 0;
        nacc = 0;
        req_valid = 1; req_op = 2'b00;
        for (int i = 0; i < 8; i++) begin
            req_tag = 4'(nacc); req_adr0 = 5'(nacc);
            @(negedge clk);
            if (req_ready) nacc++;
            @(posedge clk); #1;
        end
        req_valid = 0;
        chk("stall_accepts", nacc, 4);
        @(negedge clk);
        chk("stall_ready_low", req_ready, 0);
        @(posedge clk); #1;
        rdy_dir = 1;
        drain();
        @(negedge clk);
        chk("stall_ready_back", req_ready, 1);
        @(posedge clk); #1;

        for (int i = 0; i < 32; i++) send(2'b10, 4'd0, 5'(i), 5'd0, $urandom);
        s0 = stall_n;
        r0 = rsp_cycles.size();
        for (int i = 0; i < 32; i++) send(2'b00, 4'(i), 5'(i), 5'd0, 32'h0);
        drain();
        chk("stream_no_stall", stall_n - s0, 0);
        chk("stream_count", rsp_cycles.size() - r0, 32);
        chk("stream_no_bubble", rsp_cycles[r0 + 31] - rsp_cycles[r0], 31);

        send(2'b00, 4'd9, 5'd2, 5'd0, 32'h0);
        send(2'b11, 4'd10, 5'd3, 5'd4, 32'h0);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("post_reset_state", {req_ready, busy, rsp_valid, rd_enb_0, rd_enb_1, wr_enb_0}, 6'b100000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_reset_quiet", {rsp_valid, busy}, 0);
        end
        @(posedge clk); #1;

        rand_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
            send(2'($urandom), 4'($urandom), 5'($urandom), 5'($urandom), $urandom);
        end
        rand_mode = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
